// File: rtl/qec_frame_pkg.sv
// Shared types for the Pauli frame tracking logic: the Pauli encoding,
// the scheduler FSM states and the round-robin selector.
package qec_frame_pkg;

  // Frame entry: bit 1 = Z component, bit 0 = X component.
  typedef logic [1:0] pauli_t;

  localparam pauli_t PAULI_I = 2'b00;
  localparam pauli_t PAULI_X = 2'b01;
  localparam pauli_t PAULI_Z = 2'b10;

  typedef enum logic { IDLE = 1'b0, CLEAR = 1'b1 } pfs_state_e;

  typedef enum logic { SEL_UPD = 1'b0, SEL_Q = 1'b1 } rr_sel_e;

  // Frame bit that flips a measurement in the given basis:
  // a Z-basis result (basis 0) is flipped by X, an X-basis result by Z.
  function automatic logic flip_bit(input pauli_t p, input logic basis);
    return basis ? p[1] : p[0];
  endfunction

endpackage

// File: rtl/pauli_frame_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter (update stream vs query stream).
// The pointer only advances when both requesters compete, so a lone
// requester never disturbs the fairness order.
module rr_arb2
  import qec_frame_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_upd,
  input  logic req_q,
  output logic gnt_upd,
  output logic gnt_q
);

  rr_sel_e ptr;
  logic    contend;

  assign contend = req_upd & req_q;

  // Grant the lone requester, or the pointed-to one under contention.
  always_comb begin
    gnt_upd = 1'b0;
    gnt_q   = 1'b0;
    if (contend) begin
      gnt_upd = (ptr == SEL_UPD);
      gnt_q   = (ptr == SEL_Q);
    end else begin
      gnt_upd = req_upd;
      gnt_q   = req_q;
    end
  end

  // Hand priority to the other stream after each contended grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SEL_UPD;
    end else if (contend) begin
      ptr <= (ptr == SEL_UPD) ? SEL_Q : SEL_UPD;
    end
  end

endmodule

// File: rtl/pauli_frame_scheduler.sv
// Pauli frame scheduler: sole owner of the frame tracker's ports.
// Arbitrates decoder corrections (read-modify-write XOR) against
// measurement queries (lookup + result flip) and runs the clear sweep.
// Optional statistics counters are built when PFS_STATS_EN is defined.
//
// Handshake: a request is taken in the cycle where valid && ready.
// ready is combinational from valid, clr_req and the FSM state and is
// only ever high for the single stream being granted that cycle.
//
// The tracker's own rst_n is driven as ~rst at the integration level.
module pauli_frame_scheduler
  import qec_frame_pkg::*;
#(
  parameter int NUM_QUBITS = 49,
  parameter int ADDR_W     = $clog2(NUM_QUBITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [1:0]        upd_mask,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [ADDR_W-1:0] q_addr,
  input  logic              q_basis,
  input  logic              q_meas,
  output logic              rsp_valid,
  output logic [1:0]        rsp_pauli,
  output logic              rsp_meas,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              addr_err,
  output logic              trk_wr_en,
  output logic [ADDR_W-1:0] trk_wr_addr,
  output logic [1:0]        trk_wr_pauli,
  output logic [ADDR_W-1:0] trk_rd_addr,
  input  logic [1:0]        trk_rd_pauli,
  output logic [31:0]       stat_upd,
  output logic [31:0]       stat_q,
  output logic [31:0]       stat_stall,
  output pfs_state_e        dbg_state
);

  localparam logic [ADDR_W:0]   NQ_LIM   = (ADDR_W+1)'(NUM_QUBITS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_QUBITS - 1);

  pfs_state_e        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              arb_en, gnt_upd, gnt_q;
  logic              upd_in_rng, q_in_rng;
  pauli_t            q_pauli;

  // Streams may only be granted in IDLE and when no sweep is being requested.
  assign arb_en     = (state == IDLE) & ~clr_req;
  assign upd_in_rng = ({1'b0, upd_addr} < NQ_LIM);
  assign q_in_rng   = ({1'b0, q_addr} < NQ_LIM);
  assign upd_ready  = gnt_upd;
  assign q_ready    = gnt_q;
  assign dbg_state  = state;
  assign q_pauli    = q_in_rng ? trk_rd_pauli : PAULI_I;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_upd (upd_valid & arb_en),
    .req_q   (q_valid & arb_en),
    .gnt_upd (gnt_upd),
    .gnt_q   (gnt_q)
  );

  // FSM next state and sweep outputs.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_busy    = 1'b0;
    clr_done    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        if (clr_cnt == LAST_IDX) begin
          clr_done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and sweep counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Tracker port steering: sweep writes, update RMW, query lookup.
  always_comb begin
    trk_wr_en    = 1'b0;
    trk_wr_addr  = '0;
    trk_wr_pauli = PAULI_I;
    trk_rd_addr  = rd_addr_q;
    if (state == CLEAR) begin
      trk_wr_en   = 1'b1;
      trk_wr_addr = clr_cnt;
    end else if (gnt_upd) begin
      trk_rd_addr = upd_addr;
      if (upd_in_rng) begin
        trk_wr_en    = 1'b1;
        trk_wr_addr  = upd_addr;
        trk_wr_pauli = trk_rd_pauli ^ upd_mask;
      end
    end else if (gnt_q) begin
      trk_rd_addr = q_addr;
    end
  end

  // Read address holds between grants; response and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
      rsp_valid <= 1'b0;
      rsp_pauli <= PAULI_I;
      rsp_meas  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      rd_addr_q <= trk_rd_addr;
      rsp_valid <= gnt_q;
      if (gnt_q) begin
        rsp_pauli <= q_pauli;
        rsp_meas  <= q_meas ^ flip_bit(q_pauli, q_basis);
      end
      if ((gnt_upd & ~upd_in_rng) | (gnt_q & ~q_in_rng)) begin
        addr_err <= 1'b1;
      end
    end
  end

`ifdef PFS_STATS_EN
  logic stall_cyc;

  assign stall_cyc = (upd_valid & ~upd_ready) | (q_valid & ~q_ready);

  // Saturating grant and stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_upd   <= '0;
      stat_q     <= '0;
      stat_stall <= '0;
    end else begin
      if (gnt_upd && (stat_upd != '1)) stat_upd <= stat_upd + 32'd1;
      if (gnt_q && (stat_q != '1)) stat_q <= stat_q + 32'd1;
      if (stall_cyc && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  assign stat_upd   = '0;
  assign stat_q     = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_pauli_frame_scheduler.sv
// Testbench for pauli_frame_scheduler: directed scenarios plus random
// traffic checked every cycle against a transaction-level frame model.
module tb_pauli_frame_scheduler;
  import qec_frame_pkg::*;

  localparam int NQ = 49;
  localparam int AW = 6;
`ifdef PFS_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          upd_valid = 1'b0, q_valid = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] upd_addr = '0, q_addr = '0;
  logic [1:0]    upd_mask = '0;
  logic          q_basis = 1'b0, q_meas = 1'b0;
  logic          upd_ready, q_ready, rsp_valid, rsp_meas;
  logic          clr_busy, clr_done, addr_err, trk_wr_en;
  logic [1:0]    rsp_pauli, trk_wr_pauli, trk_rd_pauli;
  logic [AW-1:0] trk_wr_addr, trk_rd_addr;
  logic [31:0]   stat_upd, stat_q, stat_stall;
  pfs_state_e    dbg_state;

  pauli_frame_scheduler #(.NUM_QUBITS(NQ)) dut (
    .clk(clk), .rst(rst),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_mask(upd_mask),
    .q_valid(q_valid), .q_ready(q_ready), .q_addr(q_addr), .q_basis(q_basis), .q_meas(q_meas),
    .rsp_valid(rsp_valid), .rsp_pauli(rsp_pauli), .rsp_meas(rsp_meas),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .addr_err(addr_err),
    .trk_wr_en(trk_wr_en), .trk_wr_addr(trk_wr_addr), .trk_wr_pauli(trk_wr_pauli),
    .trk_rd_addr(trk_rd_addr), .trk_rd_pauli(trk_rd_pauli),
    .stat_upd(stat_upd), .stat_q(stat_q), .stat_stall(stat_stall), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Tracker stand-in: async read, sync write. Entries past NUM_QUBITS hold
  // 11 so any use of an out-of-range read shows up.
  logic [1:0] trk_mem [64];
  assign trk_rd_pauli = trk_mem[trk_rd_addr];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) trk_mem[i] <= (i < NQ) ? 2'b00 : 2'b11;
    end else if (trk_wr_en) begin
      trk_mem[trk_wr_addr] <= trk_wr_pauli;
    end
  end

  // Reference model state.
  logic [1:0] m_frame [NQ];
  int         m_ptr, m_sweep_left, m_last_rd;
  bit         m_err, rsp_due;
  logic [2:0] exp_q[$];
  int         m_upd_cnt, m_q_cnt, m_stall_cnt;
  int         gnt_log[$];
  int         obs_busy, obs_done, obs_ready_busy, obs_nonzero;
  logic [1:0] obs_wr_pauli, obs_rsp_pauli;
  logic       obs_rsp_meas;
  int         checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) m_frame[i] = 2'b00;
    m_ptr = 0; m_sweep_left = 0; m_last_rd = 0;
    m_err = 0; rsp_due = 0;
    exp_q.delete();
    m_upd_cnt = 0; m_q_cnt = 0; m_stall_cnt = 0;
  endtask

  // Compare every DUT output for the current cycle, then advance the model.
  task automatic model_check();
    bit         g_u, g_q;
    logic [1:0] p;
    logic [2:0] e;
    int         idx;
    check("rsp_valid", rsp_valid, rsp_due);
    if (rsp_due && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rsp_pauli", rsp_pauli, e[2:1]);
      check("rsp_meas", rsp_meas, e[0]);
    end
    if (rsp_valid) begin
      obs_rsp_pauli = rsp_pauli;
      obs_rsp_meas  = rsp_meas;
      if (rsp_pauli != 2'b00) obs_nonzero++;
    end
    rsp_due = 0;
    check("addr_err", addr_err, m_err);
    check("stat_upd", stat_upd, STATS_ON ? m_upd_cnt : 0);
    check("stat_q", stat_q, STATS_ON ? m_q_cnt : 0);
    check("stat_stall", stat_stall, STATS_ON ? m_stall_cnt : 0);
    check("state", dbg_state, (m_sweep_left > 0) ? CLEAR : IDLE);
    obs_busy += clr_busy;
    obs_done += clr_done;
    if (clr_busy && (upd_ready || q_ready)) obs_ready_busy++;
    if (upd_ready) gnt_log.push_back(0);
    if (q_ready) gnt_log.push_back(1);
    if (m_sweep_left > 0) begin
      idx = NQ - m_sweep_left;
      check("clr_ready", {upd_ready, q_ready}, 0);
      check("clr_busy", clr_busy, 1);
      check("clr_wr", {trk_wr_en, trk_wr_pauli}, {1'b1, 2'b00});
      check("clr_wr_addr", trk_wr_addr, idx);
      check("clr_done", clr_done, m_sweep_left == 1);
      check("clr_rd_hold", trk_rd_addr, m_last_rd);
      m_frame[idx] = 2'b00;
      m_sweep_left--;
      if (upd_valid || q_valid) m_stall_cnt++;
    end else begin
      check("idle_busy", {clr_busy, clr_done}, 0);
      g_u = 0; g_q = 0;
      if (clr_req) begin
        m_sweep_left = NQ;
      end else if (upd_valid && q_valid) begin
        if (m_ptr == 0) g_u = 1; else g_q = 1;
        m_ptr ^= 1;
      end else begin
        g_u = upd_valid;
        g_q = q_valid;
      end
      check("upd_ready", upd_ready, g_u);
      check("q_ready", q_ready, g_q);
      if ((upd_valid && !g_u) || (q_valid && !g_q)) m_stall_cnt++;
      if (g_u) begin
        m_upd_cnt++;
        check("upd_rd_addr", trk_rd_addr, upd_addr);
        m_last_rd = upd_addr;
        if (upd_addr < NQ) begin
          p = m_frame[upd_addr] ^ upd_mask;
          check("upd_wr_en", trk_wr_en, 1);
          check("upd_wr_addr", trk_wr_addr, upd_addr);
          check("upd_wr_pauli", trk_wr_pauli, p);
          obs_wr_pauli = trk_wr_pauli;
          m_frame[upd_addr] = p;
        end else begin
          check("upd_oor_wr_en", trk_wr_en, 0);
          m_err = 1;
        end
      end else begin
        check("no_wr", trk_wr_en, 0);
      end
      if (g_q) begin
        m_q_cnt++;
        check("q_rd_addr", trk_rd_addr, q_addr);
        m_last_rd = q_addr;
        if (q_addr < NQ) p = m_frame[q_addr];
        else begin
          p = 2'b00;
          m_err = 1;
        end
        exp_q.push_back({p, q_meas ^ (q_basis ? p[1] : p[0])});
        rsp_due = 1;
      end
      if (!g_u && !g_q) check("rd_hold", trk_rd_addr, m_last_rd);
    end
  endtask

  // One clock cycle: inputs already applied just after the rising edge.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit uv, input int ua, input logic [1:0] um,
                       input bit qv, input int qa, input bit qb, input bit qm,
                       input bit cr);
    upd_valid = uv; upd_addr = AW'(ua); upd_mask = um;
    q_valid = qv; q_addr = AW'(qa); q_basis = qb; q_meas = qm;
    clr_req = cr;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset with every output checked against its reset value.
  task automatic do_reset();
    upd_valid = 0; q_valid = 0; clr_req = 0;
    upd_addr = '0; q_addr = '0; upd_mask = '0; q_basis = 0; q_meas = 0;
    rst = 1'b1;
    #3;
    check("rst_outs", {upd_ready, q_ready, rsp_valid, rsp_pauli, rsp_meas, clr_busy,
                       clr_done, addr_err, trk_wr_en, trk_wr_addr, trk_wr_pauli,
                       trk_rd_addr}, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_stats", stat_upd | stat_q | stat_stall, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int a0, a1, sb;
  initial begin
    model_reset();
    obs_busy = 0; obs_done = 0; obs_ready_busy = 0; obs_nonzero = 0;
    obs_wr_pauli = '0; obs_rsp_pauli = '0; obs_rsp_meas = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single update then query of the same qubit.
    drive(1, 5, 2'b01, 0, 0, 0, 0, 0);
    check("t1_wr_pauli", obs_wr_pauli, 2'b01);
    drive(0, 0, 2'b00, 1, 5, 0, 0, 0);
    idle(1);
    check("t1_rsp_pauli", obs_rsp_pauli, 2'b01);
    check("t1_rsp_meas", obs_rsp_meas, 1'b1);

    // Back-to-back updates to one qubit, then an X-basis query right after.
    drive(1, 3, 2'b01, 0, 0, 0, 0, 0);
    drive(1, 3, 2'b11, 0, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 1, 3, 1, 1, 0);
    idle(1);
    check("t2_rsp_pauli", obs_rsp_pauli, 2'b10);
    check("t2_rsp_meas", obs_rsp_meas, 1'b0);

    // Contended streams alternate starting from the update stream.
    do_reset();
    gnt_log.delete();
    sb = stat_stall;
    for (int i = 0; i < 6; i++)
      drive(1, $urandom_range(0, NQ-1), 2'($urandom), 1, $urandom_range(0, NQ-1),
            1'($urandom), 1'($urandom), 0);
    idle(2);
    check("t3_gnt_count", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check("t3_gnt_order", gnt_log[i], i % 2);
    check("t3_stall_delta", stat_stall - sb, STATS_ON ? 6 : 0);

    // Clear sweep while both streams are pending.
    for (int i = 0; i < 30; i++)
      drive(1, $urandom_range(0, NQ-1), 2'($urandom_range(1, 3)), 0, 0, 0, 0, 0);
    obs_busy = 0; obs_done = 0; obs_ready_busy = 0;
    drive(1, 7, 2'b11, 1, 7, 0, 0, 1);
    for (int i = 0; i < NQ; i++)
      drive(1, $urandom_range(0, NQ-1), 2'b11, 1, $urandom_range(0, NQ-1), 0, 0, 0);
    idle(3);
    check("t4_busy_cycles", obs_busy, NQ);
    check("t4_done_pulses", obs_done, 1);
    check("t4_ready_in_sweep", obs_ready_busy, 0);
    obs_nonzero = 0;
    for (int a = 0; a < NQ; a++) drive(0, 0, 2'b00, 1, a, 1'($urandom), 1'($urandom), 0);
    idle(1);
    check("t4_nonzero_rsp", obs_nonzero, 0);

    // Out-of-range addresses.
    drive(1, 49, 2'b11, 0, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 1, 63, 1, 1, 0);
    idle(1);
    check("t5_rsp_pauli", obs_rsp_pauli, 2'b00);
    check("t5_rsp_meas", obs_rsp_meas, 1'b1);
    idle(4);
    check("t5_addr_err_sticky", addr_err, 1'b1);
    do_reset();
    check("t5_addr_err_cleared", addr_err, 1'b0);

    // Random traffic with occasional sweeps and out-of-range addresses.
    for (int i = 0; i < 600; i++) begin
      a0 = ($urandom_range(0, 19) == 0) ? $urandom_range(NQ, 63) : $urandom_range(0, 7);
      a1 = ($urandom_range(0, 19) == 0) ? $urandom_range(NQ, 63) : $urandom_range(0, 7);
      drive(1'($urandom_range(0, 1)), a0, 2'($urandom), 1'($urandom_range(0, 1)), a1,
            1'($urandom), 1'($urandom), $urandom_range(0, 149) == 0);
    end
    idle(NQ + 2);

    // Reset in the middle of a sweep.
    obs_done = 0;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1);
    idle(20);
    do_reset();
    idle(NQ + 2);
    check("t6_no_done", obs_done, 0);
    check("t6_busy_low", clr_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
